bin_to_bcd_seq: RTL and testbench
=================================

Name: bin_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter (iterative double-dabble), with optional two's-complement sign extraction.
- Sits between the 8-bit output register (bus-loaded on OI) and the multiplexed seven-segment driver.
- Lets the display show decimal instead of hex.
- Results are held stable between conversions, so the display never shows intermediate values.

Parameters:
- IN_WIDTH, 8, width of the binary input.
- BCD_DIGITS, 3, number of 4-bit BCD output digits. Must satisfy 10^BCD_DIGITS > 2^IN_WIDTH.

Ports:
- clk  input  1  single clock
- rst  input  1  synchronous, active-high reset
- in  input  IN_WIDTH  binary value to convert
- load  input  1  start request; sampled only in IDLE
- twos_complement  input  1  treat in as signed when high; sampled with load
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse when new results are committed
- bcd  output  4*BCD_DIGITS  result digits; digit 0 = bits [3:0] = least significant
- negative  output  1  sign of the committed result
- blank  output  BCD_DIGITS  leading-zero blank mask (see Optional Feature)

Behaviour:
- Reset (rst high at a clk edge, synchronous): state=IDLE, bcd=0, negative=0, blank=0, busy=0, done=0, counter=0, scratch registers=0. rst overrides every other input.
- States:
  - IDLE: busy=0, done=0. On load=1:
    - If twos_complement=1 and in[IN_WIDTH-1]=1: magnitude = (~in + 1) truncated to IN_WIDTH bits, sign=1.
    - Otherwise: magnitude = in, sign=0.
    - Latch magnitude into the binary shift register, clear the BCD scratch, latch sign, set counter=IN_WIDTH, go to SHIFT.
  - SHIFT: busy=1. Each cycle:
    - For every scratch digit >= 5, add 3 (4-bit result, no carry out).
    - Shift {scratch, binary} left by 1; decrement counter.
    - When counter==1 at the start of the cycle, that cycle is the final shift. At that edge, commit the post-shift scratch to bcd, commit sign to negative, update blank, and go to DONE.
  - DONE: busy=1, done=1 for exactly this cycle; next state IDLE.
- Latency:
  - load sampled at edge k.
  - SHIFT occupies cycles k+1 .. k+IN_WIDTH.
  - bcd, negative and blank update at edge k+IN_WIDTH.
  - done is high during cycle k+IN_WIDTH+1 (after edge k+IN_WIDTH+1 it is low).
  - Default (IN_WIDTH=8): 10 cycles from the load edge to return to IDLE.
- Boundary conditions:
  - load while busy (SHIFT or DONE): ignored, not queued.
  - load in IDLE for consecutive cycles: each IDLE sample starts a conversion. Back-to-back conversions are allowed, one per IN_WIDTH+2 cycles.
  - Most negative input (0x80, signed): magnitude 128; result 128 with negative=1. No overflow, since magnitude is unsigned IN_WIDTH bits.
  - twos_complement=0: negative is always 0, even when the MSB is set.
  - in or twos_complement changing during SHIFT: no effect.
  - rst during SHIFT or DONE: conversion abandoned; outputs cleared as in reset; no done pulse.
  - bcd, negative and blank change only at the commit edge or on reset.

Optional Feature:
- Macro: BIN_TO_BCD_LEADING_ZERO_BLANK_EN.
- Defined:
  - At commit, blank[i]=1 for each digit i>0 where that digit and all more-significant digits are 0.
  - blank[0] is always 0, so zero displays as a single "0".
  - The downstream driver uses blank to switch off those digits.
- Undefined:
  - blank is held at 0 at all times; no blanking logic is synthesised.

Test Plan:
- in=0x7B, twos_complement=0, load 1 cycle -> done in cycle k+9; bcd=0x123, negative=0. With macro defined, blank=3'b000.
- in=0xFF: with twos_complement=0 -> bcd=0x255, negative=0; with twos_complement=1 -> bcd=0x001, negative=1. With macro defined, blank=3'b110 for the signed case.
- in=0x80, twos_complement=1 -> bcd=0x128, negative=1. Then in=0x00 -> bcd=0x000, negative=0; with macro defined, blank=3'b110.
- Start conversion of 0x2A; pulse load with in=0x63 at cycles k+3 and k+9 -> second request ignored; bcd=0x042 at commit; done pulses exactly once; busy is contiguous from k+1 to k+9.
- Convert 0x64 (commit bcd=0x100); then start 0xC8 and assert rst at cycle k+4 -> bcd=0, negative=0, busy=0 at the next edge. No done pulse follows. A subsequent load of 0x05 yields bcd=0x005 after normal latency.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential binary-to-BCD converter using iterative
// double-dabble, with optional two's-complement sign extraction.
// It sits between the bus-loaded output register and the multiplexed
// seven-segment driver. Committed results (bcd, negative, blank) are held
// stable between conversions, so the display never shows partial values.
//
// Optional feature macro: BIN_TO_BCD_LEADING_ZERO_BLANK_EN
//   defined   -> blank[i] marks leading-zero digits (i > 0) at commit
//   undefined -> blank is tied to zero and no blanking logic exists
module bin_to_bcd_seq #(
    parameter int IN_WIDTH   = 8,
    parameter int BCD_DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [IN_WIDTH-1:0]     in,
    input  logic                    load,
    input  logic                    twos_complement,
    output logic                    busy,
    output logic                    done,
    output logic [4*BCD_DIGITS-1:0] bcd,
    output logic                    negative,
    output logic [BCD_DIGITS-1:0]   blank
);

    localparam int CW = $clog2(IN_WIDTH + 1);
    localparam int SW = 4 * BCD_DIGITS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Add 3 to every digit that is 5 or more, so that the following left
    // shift carries correctly into the next decimal digit.
    function automatic logic [SW-1:0] dabble_adjust(input logic [SW-1:0] s);
        logic [SW-1:0] r;
        r = s;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (s[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = s[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = s[4*i +: 4];
            end
        end
        return r;
    endfunction

`ifdef BIN_TO_BCD_LEADING_ZERO_BLANK_EN
    // Digit i (i > 0) is blanked when it and every more-significant digit
    // are zero. Digit 0 is never blanked so a zero value still shows "0".
    function automatic logic [BCD_DIGITS-1:0] blank_mask(input logic [SW-1:0] d);
        logic [BCD_DIGITS-1:0] m;
        logic                  all_zero;
        m        = {BCD_DIGITS{1'b0}};
        all_zero = 1'b1;
        for (int i = BCD_DIGITS - 1; i > 0; i--) begin
            if (d[4*i +: 4] != 4'd0) begin
                all_zero = 1'b0;
            end else begin
                all_zero = all_zero;
            end
            m[i] = all_zero;
        end
        m[0] = 1'b0;
        return m;
    endfunction
`endif

    state_t              state_r;
    state_t              state_next_s;
    logic [CW-1:0]       count_r;
    logic [IN_WIDTH-1:0] bin_r;
    logic [SW-1:0]       scratch_r;
    logic                sign_r;
    logic [SW-1:0]       bcd_r;
    logic                negative_r;
    logic                busy_r;
    logic                done_r;
    logic                busy_next_s;
    logic                done_next_s;

    logic [SW-1:0]       adjusted_s;
    logic [SW-1:0]       shifted_scratch_s;
    logic [IN_WIDTH-1:0] shifted_bin_s;
    logic [IN_WIDTH-1:0] magnitude_s;
    logic                sign_s;
    logic                last_shift_s;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: load is honoured only in IDLE, so requests while
    // busy are dropped rather than queued.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (load) begin
                    state_next_s = ST_SHIFT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_shift_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so busy/done come straight from flops.
    always_comb begin
        busy_next_s = 1'b0;
        done_next_s = 1'b0;
        case (state_next_s)
            ST_IDLE: begin
                busy_next_s = 1'b0;
                done_next_s = 1'b0;
            end
            ST_SHIFT: begin
                busy_next_s = 1'b1;
                done_next_s = 1'b0;
            end
            ST_DONE: begin
                busy_next_s = 1'b1;
                done_next_s = 1'b1;
            end
            default: begin
                busy_next_s = 1'b0;
                done_next_s = 1'b0;
            end
        endcase
    end

    // Status flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= busy_next_s;
            done_r <= done_next_s;
        end
    end

    // Magnitude/sign extraction of the input, used only at load time.
    // The most negative value maps to an unsigned magnitude, so no overflow.
    always_comb begin
        magnitude_s = in;
        sign_s      = 1'b0;
        if (twos_complement && in[IN_WIDTH-1]) begin
            magnitude_s = ~in + IN_WIDTH'(1);
            sign_s      = 1'b1;
        end else begin
            magnitude_s = in;
            sign_s      = 1'b0;
        end
    end

    // One double-dabble step: adjust digits, then shift {scratch, bin} left.
    always_comb begin
        adjusted_s        = dabble_adjust(scratch_r);
        shifted_scratch_s = {adjusted_s[SW-2:0], bin_r[IN_WIDTH-1]};
        shifted_bin_s     = bin_r << 1;
        last_shift_s      = (count_r == CW'(1));
    end

    // Conversion datapath and committed results; results only change at the
    // final shift edge or on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r    <= {CW{1'b0}};
            bin_r      <= {IN_WIDTH{1'b0}};
            scratch_r  <= {SW{1'b0}};
            sign_r     <= 1'b0;
            bcd_r      <= {SW{1'b0}};
            negative_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (load) begin
                        bin_r     <= magnitude_s;
                        scratch_r <= {SW{1'b0}};
                        sign_r    <= sign_s;
                        count_r   <= CW'(IN_WIDTH);
                    end else begin
                        bin_r     <= bin_r;
                    end
                end
                ST_SHIFT: begin
                    scratch_r <= shifted_scratch_s;
                    bin_r     <= shifted_bin_s;
                    count_r   <= count_r - CW'(1);
                    if (last_shift_s) begin
                        bcd_r      <= shifted_scratch_s;
                        negative_r <= sign_r;
                    end else begin
                        bcd_r      <= bcd_r;
                    end
                end
                ST_DONE: begin
                    count_r <= count_r;
                end
                default: begin
                    count_r <= {CW{1'b0}};
                end
            endcase
        end
    end

`ifdef BIN_TO_BCD_LEADING_ZERO_BLANK_EN
    logic [BCD_DIGITS-1:0] blank_r;

    // Leading-zero mask, committed together with the digits.
    always_ff @(posedge clk) begin
        if (rst) begin
            blank_r <= {BCD_DIGITS{1'b0}};
        end else if ((state_r == ST_SHIFT) && last_shift_s) begin
            blank_r <= blank_mask(shifted_scratch_s);
        end else begin
            blank_r <= blank_r;
        end
    end

    assign blank = blank_r;
`else
    assign blank = {BCD_DIGITS{1'b0}};
`endif

    assign busy     = busy_r;
    assign done     = done_r;
    assign bcd      = bcd_r;
    assign negative = negative_r;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Testbench for bin_to_bcd_seq: directed scenarios plus random traffic,
// compared every cycle against an arithmetic reference model.
module tb_bin_to_bcd_seq;

    localparam int W = 8;
    localparam int D = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [W-1:0]   din = '0;
    logic           load = 1'b0;
    logic           tc = 1'b0;
    logic           busy;
    logic           done;
    logic [4*D-1:0] bcd;
    logic           negative;
    logic [D-1:0]   blank;

    int pass_cnt = 0;
    int total_cnt = 0;
    int done_cnt = 0;
    bit started = 1'b0;

    // reference model state
    int             m_cnt = 0;
    int             m_pend_mag = 0;
    bit             m_pend_neg = 1'b0;
    logic [4*D-1:0] m_bcd = '0;
    logic           m_neg = 1'b0;
    logic [D-1:0]   m_blank = '0;

    bin_to_bcd_seq #(.IN_WIDTH(W), .BCD_DIGITS(D)) dut (
        .clk(clk), .rst(rst), .in(din), .load(load), .twos_complement(tc),
        .busy(busy), .done(done), .bcd(bcd), .negative(negative), .blank(blank)
    );

    always #5 clk = ~clk;

    function automatic logic [4*D-1:0] to_bcd(input int v);
        logic [4*D-1:0] r;
        int x;
        x = v;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [D-1:0] exp_blank(input int v);
        logic [D-1:0] r;
        int p;
        r = '0;
`ifdef BIN_TO_BCD_LEADING_ZERO_BLANK_EN
        p = 10;
        for (int i = 1; i < D; i++) begin
            r[i] = (v < p);
            p = p * 10;
        end
`else
        p = v;
`endif
        return r;
    endfunction

    function automatic int magnitude(input logic [W-1:0] v, input logic t);
        if (t && v[W-1]) return (1 << W) - int'(v);
        return int'(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a conversion occupies W+1 cycles after the load edge;
    // results appear at the edge where one cycle (the done cycle) remains.
    always @(posedge clk) begin
        if (rst) begin
            m_cnt   <= 0;
            m_bcd   <= '0;
            m_neg   <= 1'b0;
            m_blank <= '0;
        end else if (m_cnt == 0) begin
            if (load) begin
                m_cnt      <= W + 1;
                m_pend_mag <= magnitude(din, tc);
                m_pend_neg <= tc && din[W-1];
            end
        end else begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 2) begin
                m_bcd   <= to_bcd(m_pend_mag);
                m_neg   <= m_pend_neg;
                m_blank <= exp_blank(m_pend_mag);
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("busy", 32'(busy), 32'(m_cnt > 0));
            chk("done", 32'(done), 32'(m_cnt == 1));
            chk("bcd", 32'(bcd), 32'(m_bcd));
            chk("negative", 32'(negative), 32'(m_neg));
            chk("blank", 32'(blank), 32'(m_blank));
            if (done === 1'b1) done_cnt++;
        end
    end

    // Set inputs just after a rising edge; they are sampled at the next one.
    task automatic step(input logic r, input logic l, input logic [W-1:0] v, input logic t);
        @(posedge clk);
        #1;
        rst = r; load = l; din = v; tc = t;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy === 1'b1 && n < 30);
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic convert(input logic [W-1:0] v, input logic t);
        step(1'b0, 1'b1, v, t);
        step(1'b0, 1'b0, '0, 1'b0);
        wait_idle();
    endtask

    initial begin
        int dc;
        logic [D-1:0] bl;

        repeat (3) step(1'b1, 1'b0, '0, 1'b0);
        @(negedge clk);
        started = 1'b1;
        chk("reset_bcd", 32'(bcd), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        step(1'b0, 1'b0, '0, 1'b0);

        // model pins
        chk("model_123", 32'(to_bcd(123)), 32'h123);
        chk("model_mag80", 32'(magnitude(8'h80, 1'b1)), 32'd128);

        convert(8'h7B, 1'b0);
        chk("lit_7B_bcd", 32'(bcd), 32'h123);
        chk("lit_7B_neg", 32'(negative), 32'h0);
        chk("lit_7B_blank", 32'(blank), 32'h0);

        convert(8'hFF, 1'b0);
        chk("lit_FFu_bcd", 32'(bcd), 32'h255);
        chk("lit_FFu_neg", 32'(negative), 32'h0);

        convert(8'hFF, 1'b1);
        chk("lit_FFs_bcd", 32'(bcd), 32'h001);
        chk("lit_FFs_neg", 32'(negative), 32'h1);
`ifdef BIN_TO_BCD_LEADING_ZERO_BLANK_EN
        bl = 3'b110;
`else
        bl = 3'b000;
`endif
        chk("lit_FFs_blank", 32'(blank), 32'(bl));

        convert(8'h80, 1'b1);
        chk("lit_80s_bcd", 32'(bcd), 32'h128);
        chk("lit_80s_neg", 32'(negative), 32'h1);

        convert(8'h00, 1'b1);
        chk("lit_00_bcd", 32'(bcd), 32'h000);
        chk("lit_00_neg", 32'(negative), 32'h0);
        chk("lit_00_blank", 32'(blank), 32'(bl));

        // load while busy is ignored
        dc = done_cnt;
        step(1'b0, 1'b1, 8'h2A, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, 8'h63, 1'b0);
        repeat (5) step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, 8'h63, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        wait_idle();
        chk("lit_2A_bcd", 32'(bcd), 32'h042);
        chk("lit_2A_done_once", 32'(done_cnt - dc), 32'd1);

        // reset mid-conversion
        convert(8'h64, 1'b0);
        chk("lit_64_bcd", 32'(bcd), 32'h100);
        dc = done_cnt;
        step(1'b0, 1'b1, 8'hC8, 1'b0);
        repeat (3) step(1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        chk("lit_rst_bcd", 32'(bcd), 32'h0);
        chk("lit_rst_busy", 32'(busy), 32'h0);
        repeat (12) @(negedge clk);
        chk("lit_rst_no_done", 32'(done_cnt - dc), 32'd0);
        convert(8'h05, 1'b0);
        chk("lit_05_bcd", 32'(bcd), 32'h005);

        // random traffic including loads while busy and occasional resets
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 79) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
                 W'($urandom), 1'($urandom));
        end
        step(1'b0, 1'b0, '0, 1'b0);
        wait_idle();
        @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
